// File: rtl/jam_cost_table.sv
// Worker/job cost table for the assignment engine. A row-major streaming load fills
// the NxN table, then (W,J) lookups are answered with a fixed one-cycle latency.
module jam_cost_table #(
  parameter int N_WORKER = 8,
  parameter int IDX_W    = 3,
  parameter int COST_W   = 7,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [COST_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  w_i,
  input  logic [IDX_W-1:0]  j_i,
  output logic [COST_W-1:0] cost_o,
  output logic              tbl_ready_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  lookups_o
);

  localparam int PTR_W = 2 * IDX_W;
  localparam int DEPTH = N_WORKER * N_WORKER;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    lookups_q, lookups_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic                accept_s;
  logic [COST_W-1:0]   mem_q [DEPTH];

  // Next-state, load pointer, lookup counter and cost selection
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lookups_d = lookups_q;
    cost_d    = {COST_W{1'b0}};
    accept_s  = 1'b0;
    if (clr_i) begin
      // CLR wins over any beat presented in the same cycle
      state_d   = ST_LOAD;
      ptr_d     = {PTR_W{1'b0}};
      lookups_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_valid_i) begin
            accept_s = 1'b1;
            ptr_d    = ptr_q + PTR_W'(1'b1);
            if (ptr_q == PTR_LAST) begin
              state_d = ld_last_i ? ST_SERVE : ST_ERROR;
            end else if (ld_last_i) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_SERVE: begin
          cost_d = mem_q[{w_i, j_i}];
          if (lookups_q != {CNT_W{1'b1}}) begin
            lookups_d = lookups_q + CNT_W'(1'b1);
          end else begin
            lookups_d = lookups_q;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_LOAD;
          ptr_d   = {PTR_W{1'b0}};
        end
      endcase
    end
  end

  // State, pointer, counter and cost registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_LOAD;
      ptr_q     <= {PTR_W{1'b0}};
      lookups_q <= {CNT_W{1'b0}};
      cost_q    <= {COST_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lookups_q <= lookups_d;
      cost_q    <= cost_d;
    end
  end

  // Table storage; contents survive reset and are rewritten by the next full load
  always_ff @(posedge clk_i) begin
    if (accept_s && rst_ni) begin
      mem_q[ptr_q] <= ld_data_i;
    end
  end

  assign ld_ready_o  = (state_q == ST_LOAD);
  assign tbl_ready_o = (state_q == ST_SERVE);
  assign err_o       = (state_q == ST_ERROR);
  assign cost_o      = cost_q;
  assign lookups_o   = lookups_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table: table-driven lookups plus load, error,
// clear, reset and counter-saturation sequences.
module tb_jam_cost_table;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [6:0]  ld_data;
  logic        ld_last;
  logic        clr;
  logic [2:0]  w;
  logic [2:0]  j;
  logic        ld_ready, tbl_ready, err;
  logic [6:0]  cost;
  logic [15:0] lookups;
  logic        s_ld_ready, s_tbl_ready, s_err;
  logic [6:0]  s_cost;
  logic [3:0]  s_lookups;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    logic [6:0] cost;
  } vec_t;

  vec_t v0 [12];
  vec_t v1 [5];

  jam_cost_table #(.N_WORKER(8), .IDX_W(3), .COST_W(7), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .clr_i(clr), .w_i(w), .j_i(j),
    .cost_o(cost), .tbl_ready_o(tbl_ready), .err_o(err), .lookups_o(lookups)
  );

  jam_cost_table #(.N_WORKER(8), .IDX_W(3), .COST_W(7), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(s_ld_ready),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .clr_i(clr), .w_i(w), .j_i(j),
    .cost_o(s_cost), .tbl_ready_o(s_tbl_ready), .err_o(s_err), .lookups_o(s_lookups)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] data_of(input int k, input int pat);
    if (pat == 0) return 7'(k % 128);
    else return 7'((k * 5 + 17) % 128);
  endfunction

  // Stream n beats; LD_LAST on beat last_beat (-1 = never); optional idle gaps
  task automatic load_beats(input int n, input int last_beat, input int pat, input bit stalls);
    for (int k = 0; k < n; k++) begin
      if (stalls && (k % 7 == 3)) begin
        ld_valid = 1'b0;
        ld_data  = 7'h55;
        repeat (1 + k % 3) tick();
        chk("stall_no_serve", tbl_ready, 0);
      end
      ld_valid = 1'b1;
      ld_data  = data_of(k, pat);
      ld_last  = (k == last_beat);
      tick();
      if (k < n - 1) chk("load_ready_mid", ld_ready, 1);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic lookup_vec(input vec_t v, input string name);
    w = v.w;
    j = v.j;
    tick();
    chk(name, cost, v.cost);
  endtask

  initial begin
    v0[0]  = '{3'd3, 3'd5, 7'd29};
    v0[1]  = '{3'd0, 3'd0, 7'd0};
    v0[2]  = '{3'd1, 3'd1, 7'd9};
    v0[3]  = '{3'd2, 3'd2, 7'd18};
    v0[4]  = '{3'd3, 3'd3, 7'd27};
    v0[5]  = '{3'd4, 3'd4, 7'd36};
    v0[6]  = '{3'd5, 3'd5, 7'd45};
    v0[7]  = '{3'd6, 3'd6, 7'd54};
    v0[8]  = '{3'd7, 3'd7, 7'd63};
    v0[9]  = '{3'd0, 3'd7, 7'd7};
    v0[10] = '{3'd7, 3'd0, 7'd56};
    v0[11] = '{3'd6, 3'd2, 7'd50};
    v1[0]  = '{3'd3, 3'd5, 7'd34};
    v1[1]  = '{3'd0, 3'd0, 7'd17};
    v1[2]  = '{3'd7, 3'd7, 7'd76};
    v1[3]  = '{3'd2, 3'd6, 7'd127};
    v1[4]  = '{3'd4, 3'd1, 7'd54};

    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 7'd0; ld_last = 1'b0;
    clr = 1'b0; w = 3'd0; j = 3'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_tbl_ready", tbl_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_cost", cost, 0);
    chk("rst_lookups", lookups, 0);

    // Plain load, then lookups with load port driven (must be ignored)
    load_beats(64, 63, 0, 1'b0);
    chk("load_tbl_ready", tbl_ready, 1);
    chk("load_ld_ready", ld_ready, 0);
    chk("load_err", err, 0);
    chk("serve_entry_lookups", lookups, 0);
    chk("serve_entry_cost", cost, 0);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 7'h7f;
    for (int i = 0; i < 12; i++) begin
      lookup_vec(v0[i], "lookup_p0");
      chk("lookups_cnt", lookups, i + 1);
      chk("lookups_sat4", s_lookups, (i + 1 > 15) ? 15 : i + 1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("serve_ignores_load", tbl_ready, 1);
    repeat (10) tick();
    chk("lookups_cnt22", lookups, 22);
    chk("lookups_sat4_hold", s_lookups, 15);

    // CLR in SERVE
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_tbl_ready", tbl_ready, 0);
    chk("clr_cost", cost, 0);
    chk("clr_lookups", lookups, 0);
    chk("clr_ld_ready", ld_ready, 1);

    // CLR with a simultaneous beat: beat must not advance the pointer
    clr = 1'b1; ld_valid = 1'b1; ld_data = 7'h11; ld_last = 1'b0;
    tick();
    clr = 1'b0; ld_valid = 1'b0;
    load_beats(64, 63, 0, 1'b1);
    chk("stall_load_tbl_ready", tbl_ready, 1);
    chk("stall_load_err", err, 0);
    for (int i = 0; i < 4; i++) lookup_vec(v0[i], "lookup_stall");

    // Early LD_LAST -> ERROR, beats refused, CLR recovers
    clr = 1'b1; tick(); clr = 1'b0;
    load_beats(11, 10, 0, 1'b0);
    chk("early_last_err", err, 1);
    chk("early_last_ld_ready", ld_ready, 0);
    chk("early_last_cost", cost, 0);
    ld_valid = 1'b1; ld_last = 1'b1;
    repeat (3) tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("err_holds", err, 1);
    chk("err_no_serve", tbl_ready, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("err_clr_ld_ready", ld_ready, 1);
    chk("err_clr_err", err, 0);
    load_beats(64, 63, 0, 1'b0);
    chk("reload_tbl_ready", tbl_ready, 1);
    lookup_vec(v0[0], "reload_lookup");

    // 64 beats without LD_LAST -> ERROR
    clr = 1'b1; tick(); clr = 1'b0;
    load_beats(64, -1, 0, 1'b0);
    chk("no_last_err", err, 1);
    chk("no_last_tbl_ready", tbl_ready, 0);

    // Reset at beat 30, then full reload with a new pattern
    clr = 1'b1; tick(); clr = 1'b0;
    load_beats(30, -1, 1, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_ld_ready", ld_ready, 1);
    chk("midrst_lookups", lookups, 0);
    chk("midrst_cost", cost, 0);
    load_beats(64, 63, 1, 1'b0);
    chk("midrst_reload_ready", tbl_ready, 1);
    chk("midrst_reload_err", err, 0);
    for (int i = 0; i < 5; i++) lookup_vec(v1[i], "lookup_p1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
